// File: rtl/pb_button_port_pkg.sv
// Shared constants for the PicoBlaze button port: default port map, button bit
// positions and interrupt FSM encoding.
package pb_button_port_pkg;

    localparam int NUM_BTN = 4;

    localparam logic [7:0] ADDR_STATUS = 8'h0F;
    localparam logic [7:0] ADDR_RAW    = 8'h0E;
    localparam logic [7:0] ADDR_MASK   = 8'h0D;

    localparam int BTN_AUMENTA   = 0;
    localparam int BTN_DISMINUYE = 1;
    localparam int BTN_SIGUIENTE = 2;
    localparam int BTN_ANTERIOR  = 3;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_ASSERT     = 2'd1;
    localparam logic [1:0] ST_WAIT_CLEAR = 2'd2;

    // Every readable register is a 4-bit button vector zero-extended onto the bus.
    function automatic logic [7:0] zext_nibble(input logic [3:0] v);
        return {4'h0, v};
    endfunction

endpackage

// File: rtl/pb_button_port_debounce.sv
// One button: two-flop synchroniser, stability counter and debounced level,
// with a single-cycle pulse on the cycle the level rises.
module button_debounce #(
    parameter int DB_COUNT = 50000,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;
    logic             done;

    assign done = (cnt == CNT_LAST);

    // rise is combinational so the event lands in the same edge as the level
    assign rise = sync_p1 & ~level & done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (done) begin
                level <= sync_p1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/pb_button_port.sv
// PicoBlaze input peripheral: debounced front-panel buttons, pending press
// events with read-to-clear, interrupt mask and KCPSM3 interrupt handshake.
module pb_button_port
    import pb_button_port_pkg::*;
#(
    parameter int         DB_COUNT    = 50000,
    parameter int         CNT_W       = 16,
    parameter logic [7:0] PORT_STATUS = ADDR_STATUS,
    parameter logic [7:0] PORT_RAW    = ADDR_RAW,
    parameter logic [7:0] PORT_MASK   = ADDR_MASK
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       aumenta,
    input  logic       disminuye,
    input  logic       siguiente,
    input  logic       anterior,
    input  logic [7:0] port_id,
    input  logic       read_strobe,
    input  logic       write_strobe,
    input  logic [7:0] out_port,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       interrupt_ack
);

    logic [NUM_BTN-1:0] btn_pins;
    logic [NUM_BTN-1:0] stable;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] pending;
    logic [NUM_BTN-1:0] mask;
    logic [1:0]         state;
    logic [1:0]         next_state;
    logic               read_clear;
    logic               mask_write;
    logic               irq_req;
    logic               unused_out_hi;

    assign btn_pins[BTN_AUMENTA]   = aumenta;
    assign btn_pins[BTN_DISMINUYE] = disminuye;
    assign btn_pins[BTN_SIGUIENTE] = siguiente;
    assign btn_pins[BTN_ANTERIOR]  = anterior;

    assign unused_out_hi = ^out_port[7:4];

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debounce #(
            .DB_COUNT (DB_COUNT),
            .CNT_W    (CNT_W)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .btn   (btn_pins[i]),
            .level (stable[i]),
            .rise  (rise[i])
        );
    end

    function automatic logic [7:0] read_mux(
        input logic [7:0] addr,
        input logic [3:0] pend,
        input logic [3:0] stab,
        input logic [3:0] msk
    );
        logic [7:0] data;
        data = 8'h00;
        if (addr == PORT_STATUS) data = zext_nibble(pend);
        else if (addr == PORT_RAW) data = zext_nibble(stab);
        else if (addr == PORT_MASK) data = zext_nibble(msk);
        return data;
    endfunction

    assign read_clear = read_strobe && (port_id == PORT_STATUS);
    assign mask_write = write_strobe && (port_id == PORT_MASK);
    assign irq_req    = |(pending & mask);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_port <= 8'h00;
        end else begin
            in_port <= read_mux(port_id, pending, stable, mask);
        end
    end

    // Clear only what the registered in_port showed; same-cycle events survive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else if (read_clear) begin
            pending <= (pending & ~in_port[3:0]) | rise;
        end else begin
            pending <= pending | rise;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask <= 4'hF;
        end else if (mask_write) begin
            mask <= out_port[3:0];
        end
    end

    // WAIT_CLEAR holds off re-interrupting until the ISR has read the events.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:       if (irq_req)       next_state = ST_ASSERT;
            ST_ASSERT:     if (interrupt_ack) next_state = ST_WAIT_CLEAR;
            ST_WAIT_CLEAR: if (!irq_req)      next_state = ST_IDLE;
            default:                          next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            interrupt <= 1'b0;
        end else begin
            state     <= next_state;
            interrupt <= (next_state == ST_ASSERT);
        end
    end

endmodule

// File: tb/tb_pb_button_port.sv
// Bench for pb_button_port: register-access vector table, directed debounce and
// interrupt sequences, then randomized traffic against a sliding-window model.
module tb_pb_button_port;

    localparam int         DB       = 4;
    localparam logic [7:0] P_STATUS = 8'h0F;
    localparam logic [7:0] P_RAW    = 8'h0E;
    localparam logic [7:0] P_MASK   = 8'h0D;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn = 4'h0;
    logic [7:0] port_id = P_MASK;
    logic       read_strobe = 1'b0;
    logic       write_strobe = 1'b0;
    logic [7:0] out_port = 8'h00;
    logic       interrupt_ack = 1'b0;
    logic [7:0] in_port;
    logic       interrupt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pb_button_port #(
        .DB_COUNT (DB),
        .CNT_W    (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .aumenta       (btn[0]),
        .disminuye     (btn[1]),
        .siguiente     (btn[2]),
        .anterior      (btn[3]),
        .port_id       (port_id),
        .read_strobe   (read_strobe),
        .write_strobe  (write_strobe),
        .out_port      (out_port),
        .in_port       (in_port),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack)
    );

    // Reference model: a level is accepted once the last DB synchronised
    // samples (pin samples 2..DB+1 edges old) all disagree with it.
    typedef struct packed {
        logic [DB+1:0][3:0] hist;
        logic [3:0]         stable;
        logic [3:0]         pending;
        logic [3:0]         mask;
        logic [7:0]         in_port;
        logic               irq;
        logic               waiting;
    } mstate_t;

    localparam mstate_t M_RESET = '{hist: '0, stable: 4'h0, pending: 4'h0, mask: 4'hF,
                                    in_port: 8'h00, irq: 1'b0, waiting: 1'b0};

    function automatic mstate_t model_step(input mstate_t s, input logic [3:0] pins,
                                           input logic [7:0] pid, input logic rd,
                                           input logic wr, input logic [7:0] dout,
                                           input logic ack);
        mstate_t    n;
        logic [3:0] rises;
        logic       all_differ;
        n = s;
        for (int i = DB + 1; i > 0; i--) n.hist[i] = s.hist[i-1];
        n.hist[0] = pins;
        rises = 4'h0;
        for (int b = 0; b < 4; b++) begin
            all_differ = 1'b1;
            for (int j = 2; j <= DB + 1; j++)
                if (n.hist[j][b] == s.stable[b]) all_differ = 1'b0;
            if (all_differ) begin
                n.stable[b] = ~s.stable[b];
                rises[b]    = ~s.stable[b];
            end
        end
        if (pid == P_STATUS)      n.in_port = {4'h0, s.pending};
        else if (pid == P_RAW)    n.in_port = {4'h0, s.stable};
        else if (pid == P_MASK)   n.in_port = {4'h0, s.mask};
        else                      n.in_port = 8'h00;
        if (rd && pid == P_STATUS) n.pending = (s.pending & ~s.in_port[3:0]) | rises;
        else                       n.pending = s.pending | rises;
        if (wr && pid == P_MASK) n.mask = dout[3:0];
        if (!s.irq && !s.waiting) begin
            if ((s.pending & s.mask) != 4'h0) n.irq = 1'b1;
        end else if (s.irq) begin
            if (ack) begin
                n.irq     = 1'b0;
                n.waiting = 1'b1;
            end
        end else if ((s.pending & s.mask) == 4'h0) begin
            n.waiting = 1'b0;
        end
        return n;
    endfunction

    mstate_t m = M_RESET;

    always @(posedge clk or posedge reset) begin
        if (reset) m <= M_RESET;
        else       m <= model_step(m, btn, port_id, read_strobe, write_strobe, out_port, interrupt_ack);
    end

    typedef struct {
        logic [7:0] port;
        logic       rd;
        logic       wr;
        logic [7:0] dout;
        logic [7:0] exp_in;
        logic       exp_irq;
    } vec_t;

    vec_t tbl [12];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_io(input string name, input logic [7:0] exp_in, input logic exp_irq);
        check({name, "_in_port"}, in_port, exp_in);
        check({name, "_irq"}, {7'h0, interrupt}, {7'h0, exp_irq});
    endtask

    task automatic ack_pulse();
        interrupt_ack = 1'b1;
        cyc();
        interrupt_ack = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{P_MASK,   1'b0, 1'b0, 8'h00, 8'h0F, 1'b0};
        tbl[1]  = '{P_RAW,    1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[2]  = '{P_STATUS, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[3]  = '{8'h00,    1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[4]  = '{P_MASK,   1'b0, 1'b1, 8'h35, 8'h0F, 1'b0};
        tbl[5]  = '{P_MASK,   1'b0, 1'b0, 8'h00, 8'h05, 1'b0};
        tbl[6]  = '{P_RAW,    1'b0, 1'b1, 8'hA2, 8'h00, 1'b0};
        tbl[7]  = '{P_MASK,   1'b0, 1'b0, 8'h00, 8'h05, 1'b0};
        tbl[8]  = '{P_MASK,   1'b0, 1'b1, 8'hFF, 8'h05, 1'b0};
        tbl[9]  = '{P_MASK,   1'b0, 1'b0, 8'h00, 8'h0F, 1'b0};
        tbl[10] = '{8'hFF,    1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[11] = '{P_STATUS, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};

        // Reset held while buttons toggle
        reset = 1'b1;
        port_id = P_MASK;
        for (int i = 0; i < 8; i++) begin
            btn = 4'(i * 5);
            cyc();
            check_io("reset_hold", 8'h00, 1'b0);
        end
        btn = 4'h0;
        reset = 1'b0;
        cyc();
        check_io("reset_mask", 8'h0F, 1'b0);

        for (int i = 0; i < 12; i++) begin
            port_id      = tbl[i].port;
            read_strobe  = tbl[i].rd;
            write_strobe = tbl[i].wr;
            out_port     = tbl[i].dout;
            cyc();
            check_io($sformatf("tbl%0d", i), tbl[i].exp_in, tbl[i].exp_irq);
        end
        read_strobe = 1'b0;
        write_strobe = 1'b0;

        // Clean press of siguiente: level after 2+DB edges, visible one later
        port_id = P_RAW;
        btn[2] = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            cyc();
            check_io($sformatf("sig_t%0d", t), (t >= 7) ? 8'h04 : 8'h00, t >= 7);
        end
        port_id = P_STATUS;
        cyc();
        check_io("sig_pending", 8'h04, 1'b1);
        btn[2] = 1'b0;
        idle(8);
        check_io("sig_release", 8'h04, 1'b1);
        ack_pulse();
        check_io("sig_ack", 8'h04, 1'b0);
        cyc();
        check_io("sig_wait", 8'h04, 1'b0);
        read_strobe = 1'b1;
        cyc();
        read_strobe = 1'b0;
        check_io("sig_read", 8'h04, 1'b0);
        cyc();
        check_io("sig_cleared", 8'h00, 1'b0);
        idle(2);
        check_io("sig_idle", 8'h00, 1'b0);

        // Bouncing aumenta: 3 high / 1 low three times, then steady
        port_id = P_RAW;
        for (int t = 1; t <= 20; t++) begin
            btn[0] = (t >= 13) ? 1'b1 : ((t % 4) != 0);
            cyc();
            check_io($sformatf("bounce_t%0d", t), (t >= 19) ? 8'h01 : 8'h00, t >= 19);
        end
        port_id = P_STATUS;
        cyc();
        check_io("bounce_pending", 8'h01, 1'b1);
        ack_pulse();
        check_io("hs_ack", 8'h01, 1'b0);
        cyc();
        check_io("hs_wait", 8'h01, 1'b0);
        read_strobe = 1'b1;
        cyc();
        read_strobe = 1'b0;
        check_io("hs_read", 8'h01, 1'b0);
        cyc();
        check_io("hs_cleared", 8'h00, 1'b0);
        btn[0] = 1'b0;
        idle(8);
        btn[0] = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            cyc();
            check_io($sformatf("repress_t%0d", t), (t >= 7) ? 8'h01 : 8'h00, t >= 7);
        end
        ack_pulse();
        read_strobe = 1'b1;
        cyc();
        read_strobe = 1'b0;
        cyc();
        check_io("repress_cleared", 8'h00, 1'b0);
        btn[0] = 1'b0;
        idle(8);

        // Mask 0x02: anterior pends silently, disminuye interrupts
        port_id = P_MASK;
        write_strobe = 1'b1;
        out_port = 8'h02;
        cyc();
        write_strobe = 1'b0;
        check_io("mask_wr", 8'h0F, 1'b0);
        cyc();
        check_io("mask_rd", 8'h02, 1'b0);
        port_id = P_STATUS;
        btn[3] = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            cyc();
            check_io($sformatf("masked_t%0d", t), (t >= 7) ? 8'h08 : 8'h00, 1'b0);
        end
        btn[3] = 1'b0;
        idle(8);
        btn[1] = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            cyc();
            check_io($sformatf("unmasked_t%0d", t), (t >= 7) ? 8'h0A : 8'h08, t >= 7);
        end
        port_id = P_MASK;
        write_strobe = 1'b1;
        out_port = 8'h00;
        cyc();
        write_strobe = 1'b0;
        check_io("mask0_assert", 8'h02, 1'b1);
        cyc();
        check_io("mask0_hold", 8'h00, 1'b1);
        ack_pulse();
        check_io("mask0_ack", 8'h00, 1'b0);
        port_id = P_STATUS;
        cyc();
        check_io("mask0_status", 8'h0A, 1'b0);
        read_strobe = 1'b1;
        cyc();
        read_strobe = 1'b0;
        cyc();
        check_io("mask0_cleared", 8'h00, 1'b0);
        btn[1] = 1'b0;
        port_id = P_MASK;
        write_strobe = 1'b1;
        out_port = 8'hFF;
        cyc();
        write_strobe = 1'b0;
        cyc();
        check_io("mask_restore", 8'h0F, 1'b0);
        idle(8);

        // Read-clear race: anterior rises in the same edge as the read
        btn[0] = 1'b1;
        idle(7);
        check_io("race_setup", 8'h0F, 1'b1);
        port_id = P_STATUS;
        cyc();
        btn[3] = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            read_strobe = (t == 6);
            cyc();
        end
        read_strobe = 1'b0;
        check_io("race_read", 8'h01, 1'b1);
        cyc();
        check_io("race_after", 8'h08, 1'b1);
        ack_pulse();
        read_strobe = 1'b1;
        cyc();
        read_strobe = 1'b0;
        cyc();
        check_io("race_cleared", 8'h00, 1'b0);
        btn = 4'h0;
        idle(10);
        check_io("race_idle", 8'h00, 1'b0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 399) == 0);
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) btn[b] = ~btn[b];
            case ($urandom_range(0, 3))
                0:       port_id = P_STATUS;
                1:       port_id = P_RAW;
                2:       port_id = P_MASK;
                default: port_id = 8'($urandom);
            endcase
            read_strobe   = ($urandom_range(0, 2) == 0);
            write_strobe  = ($urandom_range(0, 7) == 0);
            out_port      = 8'($urandom);
            interrupt_ack = ($urandom_range(0, 5) == 0);
            cyc();
            check_io("rnd", m.in_port, m.irq);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
